// File: rtl/cnn_out_stage_pkg.sv
// Shared widths for the CNN output stage: lane count, accumulator/bias/output
// widths, requantisation shift width and output FIFO sizing.
package cnn_out_stage_pkg;
  localparam int CO         = 16;
  localparam int ACI_BW     = 22;
  localparam int B_BW       = 16;
  localparam int AB_BW      = ((ACI_BW > B_BW) ? ACI_BW : B_BW) + 1;
  localparam int O_F_BW     = 8;
  localparam int SH_BW      = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_BW     = 16;
endpackage

// File: rtl/cnn_out_stage_if.sv
// Accumulator input bus and feature-map output handshake of cnn_out_stage.
interface cnn_out_stage_if;
  import cnn_out_stage_pkg::*;

  logic                     in_valid_i;
  logic [CO*ACI_BW-1:0]     in_ci_acc_i;
  logic [CO*B_BW-1:0]       bias_i;
  logic [SH_BW-1:0]         shift_i;
  logic                     ot_ready_i;
  logic                     ot_valid_o;
  logic [CO*O_F_BW-1:0]     ot_fmap_o;
  logic                     fifo_full_o;
  logic                     overflow_o;
  logic [CNT_BW-1:0]        ot_cnt_o;

  modport slave (
    input  in_valid_i, in_ci_acc_i, bias_i, shift_i, ot_ready_i,
    output ot_valid_o, ot_fmap_o, fifo_full_o, overflow_o, ot_cnt_o
  );

  modport master (
    output in_valid_i, in_ci_acc_i, bias_i, shift_i, ot_ready_i,
    input  ot_valid_o, ot_fmap_o, fifo_full_o, overflow_o, ot_cnt_o
  );
endinterface

// File: rtl/cnn_out_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO without a pop is dropped
// and reported on drop_o.
module cnn_out_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end
endmodule

// File: rtl/cnn_out_stage.sv
// Bias add, logical right shift and saturation of CO accumulator lanes, feeding
// a small output FIFO. No backpressure upstream: overflow is flagged, not stalled.
module cnn_out_stage
  import cnn_out_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              soft_reset_i,
  cnn_out_stage_if.slave    bus
);
  localparam int OMAX = (1 << O_F_BW) - 1;

  function automatic logic [O_F_BW-1:0] shift_sat(input logic [AB_BW-1:0] s,
                                                  input logic [SH_BW-1:0] sh);
    logic [AB_BW-1:0]  q;
    logic [O_F_BW-1:0] r;
    q = (int'(sh) >= AB_BW) ? '0 : (s >> sh);
    r = (q > AB_BW'(OMAX)) ? '1 : q[O_F_BW-1:0];
    return r;
  endfunction

  logic                   vld_p1_q, vld_p1_d;
  logic                   vld_p2_q, vld_p2_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_BW-1:0]      ot_cnt_q, ot_cnt_d;
  logic [CO*O_F_BW-1:0]   fifo_din;
  logic                   fifo_empty, fifo_drop;

  always_comb begin
    vld_p1_d   = bus.in_valid_i;
    vld_p2_d   = vld_p1_q;
    overflow_d = overflow_q | fifo_drop;
    ot_cnt_d   = ot_cnt_q + CNT_BW'(bus.ot_valid_o & bus.ot_ready_i);
    if (soft_reset_i) begin
      vld_p1_d   = 1'b0;
      vld_p2_d   = 1'b0;
      overflow_d = 1'b0;
      ot_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      overflow_q <= 1'b0;
      ot_cnt_q   <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      overflow_q <= overflow_d;
      ot_cnt_q   <= ot_cnt_d;
    end
  end

  for (genvar c = 0; c < CO; c++) begin : g_lane
    logic [AB_BW-1:0]  s1_p1_q, s1_p1_d;
    logic [O_F_BW-1:0] o_p2_q, o_p2_d;

    always_comb begin
      s1_p1_d = s1_p1_q;
      o_p2_d  = o_p2_q;
      // p0 -> p1: bias add, one bit wider so it cannot overflow
      if (bus.in_valid_i)
        s1_p1_d = AB_BW'(bus.in_ci_acc_i[c*ACI_BW +: ACI_BW]) +
                  AB_BW'(bus.bias_i[c*B_BW +: B_BW]);
      // p1 -> p2: requantise with the shift present at this edge
      if (vld_p1_q)
        o_p2_d = shift_sat(s1_p1_q, bus.shift_i);
    end

    always_ff @(posedge clk) begin
      s1_p1_q <= s1_p1_d;
      o_p2_q  <= o_p2_d;
    end

    assign fifo_din[c*O_F_BW +: O_F_BW] = o_p2_q;
  end

  // p2 -> FIFO
  cnn_out_fifo #(
    .DATA_W (CO*O_F_BW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (soft_reset_i),
    .push_i  (vld_p2_q),
    .pop_i   (bus.ot_ready_i),
    .din_i   (fifo_din),
    .dout_o  (bus.ot_fmap_o),
    .full_o  (bus.fifo_full_o),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign bus.ot_valid_o = ~fifo_empty;
  assign bus.overflow_o = overflow_q;
  assign bus.ot_cnt_o   = ot_cnt_q;
endmodule

// File: tb/tb_cnn_out_stage.sv
// Directed-plus-random bench for cnn_out_stage against a queue-based
// transaction model of the bias/shift/saturate pipeline and output FIFO.
module tb_cnn_out_stage;
  import cnn_out_stage_pkg::*;
  localparam int FW = CO*O_F_BW;

  logic clk = 1'b0;
  logic reset_n;
  logic soft_reset_i;

  cnn_out_stage_if bus();

  cnn_out_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_reset_i (soft_reset_i),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: two pipeline slots and the FIFO as a queue.
  logic [FW-1:0]      mq[$];
  bit                 m_v1, m_v2, m_ovf;
  int                 m_sum1 [CO];
  logic [FW-1:0]      m_o2;
  logic [CNT_BW-1:0]  m_cnt;
  logic [CNT_BW-1:0]  cnt_base;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input bit rdy, input bit sr);
    bit     pop;
    longint s, q;
    int     sh;
    pop = (mq.size() > 0) && rdy;
    if (sr) begin
      mq.delete();
      m_v1 = 0; m_v2 = 0; m_ovf = 0; m_cnt = '0;
      return;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_cnt = m_cnt + 1'b1;
    end
    if (m_v2) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back(m_o2);
      else m_ovf = 1;
    end
    if (m_v1) begin
      sh = int'(bus.shift_i);
      for (int c = 0; c < CO; c++) begin
        s = longint'(m_sum1[c]);
        q = s / (longint'(1) << sh);
        if (q > 255) q = 255;
        m_o2[c*O_F_BW +: O_F_BW] = O_F_BW'(q);
      end
    end
    m_v2 = m_v1;
    if (v) begin
      for (int c = 0; c < CO; c++)
        m_sum1[c] = int'(bus.in_ci_acc_i[c*ACI_BW +: ACI_BW]) + int'(bus.bias_i[c*B_BW +: B_BW]);
    end
    m_v1 = v;
  endtask

  task automatic check_all();
    check("valid", FW'(bus.ot_valid_o), FW'(mq.size() > 0));
    check("full", FW'(bus.fifo_full_o), FW'(mq.size() == FIFO_DEPTH));
    check("overflow", FW'(bus.overflow_o), FW'(m_ovf));
    check("cnt", FW'(bus.ot_cnt_o), FW'(m_cnt));
    if (mq.size() > 0) check("fmap", bus.ot_fmap_o, mq[0]);
  endtask

  task automatic step(input bit v, input bit rdy, input bit sr = 1'b0);
    bus.in_valid_i = v;
    bus.ot_ready_i = rdy;
    soft_reset_i   = sr;
    @(posedge clk);
    model_edge(v, rdy, sr);
    #1;
    soft_reset_i = 1'b0;
    check_all();
  endtask

  task automatic set_lane(input int c, input int a, input int b);
    bus.in_ci_acc_i[c*ACI_BW +: ACI_BW] = ACI_BW'(a);
    bus.bias_i[c*B_BW +: B_BW]          = B_BW'(b);
  endtask

  task automatic rand_lanes();
    for (int c = 0; c < CO; c++)
      set_lane(c, int'($urandom & 32'h3F_FFFF), int'($urandom & 32'hFFFF));
  endtask

  initial begin
    reset_n        = 1'b0;
    soft_reset_i   = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.ot_ready_i = 1'b0;
    bus.in_ci_acc_i = '0;
    bus.bias_i     = '0;
    bus.shift_i    = '0;
    m_v1 = 0; m_v2 = 0; m_ovf = 0; m_cnt = '0; m_o2 = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_all();
    check("reset_fmap", bus.ot_fmap_o, '0);

    // Single beat: 1000+24 >> 2 = 256 saturates; 100 >> 2 = 25.
    rand_lanes();
    set_lane(0, 1000, 24);
    bus.shift_i = 5'd2;
    step(1, 1);
    step(0, 1);
    check("lat_not_yet", FW'(bus.ot_valid_o), FW'(0));
    step(0, 1);
    check("lat3_valid", FW'(bus.ot_valid_o), FW'(1));
    check("sat256", FW'(bus.ot_fmap_o[7:0]), FW'(8'd255));
    step(0, 1);
    check("cnt1", FW'(bus.ot_cnt_o), FW'(1));
    set_lane(0, 100, 0);
    step(1, 1); step(0, 1); step(0, 1);
    check("q25", FW'(bus.ot_fmap_o[7:0]), FW'(8'd25));
    step(0, 1);

    // Shift edges: shift 0 boundary at 255/256 and shift >= AB_BW.
    bus.shift_i = 5'd0;
    set_lane(0, 200, 55);
    step(1, 1); step(0, 1); step(0, 1);
    check("sh0_255", FW'(bus.ot_fmap_o[7:0]), FW'(8'd255));
    set_lane(0, 200, 56);
    step(1, 1); step(0, 1); step(0, 1);
    check("sh0_256", FW'(bus.ot_fmap_o[7:0]), FW'(8'd255));
    rand_lanes();
    bus.shift_i = 5'd23;
    step(1, 1); step(0, 1); step(0, 1);
    check("sh23_zero", bus.ot_fmap_o, '0);
    step(0, 1);

    // Backpressure fill and overflow.
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      rand_lanes();
      bus.shift_i = 5'($urandom_range(8, 16));
      step(1, 0);
    end
    step(0, 0);
    check("bp_full", FW'(bus.fifo_full_o), FW'(1));
    check("bp_no_ovf", FW'(bus.overflow_o), FW'(0));
    step(0, 0);
    check("bp_ovf", FW'(bus.overflow_o), FW'(1));
    repeat (6) step(0, 1);
    check("bp_cnt4", FW'(bus.ot_cnt_o), FW'(4));

    // Full with concurrent pop and push.
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      rand_lanes();
      step(1, 0);
    end
    for (int i = 0; i < 8; i++) begin
      rand_lanes();
      bus.shift_i = 5'($urandom_range(6, 18));
      step(1, 1);
    end
    check("fp_still_full", FW'(bus.fifo_full_o), FW'(1));
    check("fp_no_ovf", FW'(bus.overflow_o), FW'(0));
    repeat (8) step(0, 1);

    // Streaming with ready at 50%, shift changing every cycle.
    step(0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      rand_lanes();
      bus.shift_i = 5'($urandom_range(8, 14));
      step(1, bit'(i % 2 == 0));
    end
    repeat (8) step(0, 1);

    // Streaming with continuous ready.
    step(0, 1, 1);
    cnt_base = bus.ot_cnt_o;
    for (int i = 0; i < 64; i++) begin
      rand_lanes();
      bus.shift_i = 5'($urandom_range(8, 14));
      step(1, 1);
    end
    repeat (6) step(0, 1);
    check("stream_cnt64", FW'(bus.ot_cnt_o - cnt_base), FW'(64));
    check("stream_no_ovf", FW'(bus.overflow_o), FW'(0));

    // Soft reset with two entries buffered and one beat in stage 2.
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      rand_lanes();
      step(1, 0);
    end
    step(0, 1, 1);
    check("sr_valid0", FW'(bus.ot_valid_o), FW'(0));
    check("sr_cnt0", FW'(bus.ot_cnt_o), FW'(0));
    rand_lanes();
    bus.shift_i = 5'd10;
    step(1, 1); step(0, 1); step(0, 1);
    check("sr_after_valid", FW'(bus.ot_valid_o), FW'(1));
    repeat (3) step(0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
